// File: rtl/count_seq_pkg.sv
// count_seq_pkg
//   Shared definitions for the count sequencer: FSM state encoding,
//   default datapath widths and command mode constants.
package count_seq_pkg;

    localparam int DEF_WIDTH = 4;  // counter width
    localparam int DEF_REP_W = 4;  // pass-count width

    // cmd_mode values
    localparam logic MODE_COUNTED = 1'b0;  // run cmd_reps passes, then done
    localparam logic MODE_CONT    = 1'b1;  // run until aborted

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_counter.sv
// seq_counter
//   Up-counter with synchronous clear and enable. Clear has priority
//   over enable. Wraps modulo 2^WIDTH.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   clr  synchronous clear to 0
//   en   increment enable
//   q    counter value (registered)
module seq_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer
//   Accepts a command (terminal value, pass count, mode) over valid/ready,
//   clears the counter and steps it 0..limit, repeating for the requested
//   number of passes (or forever in continuous mode) until done or abort.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cmd_valid/cmd_ready command handshake (cmd_ready is combinational)
//   cmd_limit           terminal count value
//   cmd_reps            number of passes, 0 treated as 1
//   cmd_mode            MODE_COUNTED or MODE_CONT
//   abort               kill the active sequence (ignored in IDLE and DONE)
//   q                   counter value
//   busy                high in CLEAR, RUN, DONE
//   wrap, done, aborted single-cycle registered pulses
//   reps_left           passes remaining, including the current one
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             cmd_mode,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             aborted,
    output logic [REP_W-1:0] reps_left
);

    state_t           state;
    logic [WIDTH-1:0] limit_r;
    logic             mode_r;
    logic             at_limit;
    logic             clr;
    logic             en;

    assign at_limit  = (q == limit_r);
    assign cmd_ready = (state == IDLE) && rst;
    assign busy      = (state != IDLE);

    // The counter is cleared on entry to a sequence, at the end of every
    // pass and on abort; it only advances while running.
    assign clr = (state == CLEAR) || ((state == RUN) && (abort || at_limit));
    assign en  = (state == RUN);

    seq_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .q   (q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: every register here, including the latched command
            // fields, is reset so outputs are defined straight after reset.
            state     <= IDLE;
            limit_r   <= '0;
            mode_r    <= MODE_COUNTED;
            reps_left <= '0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            // Pulses default low so each is high for exactly one cycle.
            wrap    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        limit_r   <= cmd_limit;
                        mode_r    <= cmd_mode;
                        reps_left <= (cmd_reps == '0) ? REP_W'(1) : cmd_reps;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        aborted   <= 1'b1;
                        reps_left <= '0;
                        state     <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Abort takes priority over a coincident wrap or done.
                    if (abort) begin
                        aborted   <= 1'b1;
                        reps_left <= '0;
                        state     <= IDLE;
                    end else if (at_limit) begin
                        wrap <= 1'b1;
                        if (mode_r == MODE_COUNTED) begin
                            if (reps_left == REP_W'(1)) begin
                                done      <= 1'b1;
                                reps_left <= '0;
                                state     <= DONE;
                            end else begin
                                reps_left <= reps_left - REP_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer
//   Self-checking bench for count_sequencer. Expected per-cycle outputs come
//   from a timing model: cycle c after command acceptance (c=1 is the
//   first cycle after the accepting edge) is computed arithmetically from
//   limit, pass count, mode and the cycle an abort was applied.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_limit;
    logic [3:0] cmd_reps;
    logic       cmd_mode;
    logic       abort;
    logic [3:0] q;
    logic       busy;
    logic       wrap;
    logic       done;
    logic       aborted;
    logic [3:0] reps_left;

    int checks = 0;
    int errors = 0;

    count_sequencer #(
        .WIDTH (4),
        .REP_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_limit (cmd_limit),
        .cmd_reps  (cmd_reps),
        .cmd_mode  (cmd_mode),
        .abort     (abort),
        .q         (q),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done),
        .aborted   (aborted),
        .reps_left (reps_left)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] q;
        logic       busy;
        logic       wrap;
        logic       done;
        logic       aborted;
        logic       ready;
        bit         chk_reps;
        logic [3:0] reps;
    } exp_t;

    // Expected outputs at cycle c after acceptance. a is the cycle during
    // which abort was held high (0 = never).
    function automatic exp_t model(input int c, input int lim, input int reps,
                                   input bit mode, input int a);
        exp_t e;
        int   plen  = lim + 1;
        int   total = mode ? (1 << 30) : reps * plen;  // cycles spent in RUN
        bit   eff   = (a >= 1) && (a < 2 + total);     // abort in CLEAR/RUN
        int   t;
        e.q = 4'd0; e.busy = 1'b0; e.wrap = 1'b0; e.done = 1'b0;
        e.aborted = 1'b0; e.ready = 1'b1; e.chk_reps = 1'b0; e.reps = 4'd0;
        if (eff && c > a) begin
            e.aborted = (c == a + 1);
            return e;
        end
        if (c == 1) begin
            e.busy = 1'b1; e.ready = 1'b0;
            e.chk_reps = 1'b1; e.reps = 4'(reps);
        end else if (c < 2 + total) begin
            t = c - 2;
            e.busy = 1'b1; e.ready = 1'b0;
            e.q    = 4'(t % plen);
            e.wrap = (t > 0) && (t % plen == 0);
            e.chk_reps = 1'b1;
            e.reps = mode ? 4'(reps) : 4'(reps - t / plen);
        end else if (c == 2 + total) begin
            e.busy = 1'b1; e.ready = 1'b0;
            e.wrap = 1'b1; e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, then compare n cycles against the model. With
    // keep set, cmd_valid stays high carrying the next command (lim2/reps2).
    task automatic run_seq(input string name, input int lim, input int reps,
                           input bit mode, input int a, input int n,
                           input bit keep, input int lim2, input int reps2);
        exp_t       e;
        int         reff = (reps == 0) ? 1 : reps;
        logic [5:0] got_v;
        logic [5:0] exp_v;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_start got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_limit = 4'(lim);
        cmd_reps  = 4'(reps);
        cmd_mode  = mode;
        step();
        if (keep) begin
            cmd_limit = 4'(lim2);
            cmd_reps  = 4'(reps2);
            cmd_mode  = 1'b0;
        end else begin
            cmd_valid = 1'b0;
        end
        for (int c = 1; c <= n; c++) begin
            e     = model(c, lim, reff, mode, a);
            got_v = {q, busy, wrap} ^ 6'd0;
            got_v = {busy, wrap, done, aborted, cmd_ready, 1'b0};
            exp_v = {e.busy, e.wrap, e.done, e.aborted, e.ready, 1'b0};
            checks++;
            if (q !== e.q || got_v !== exp_v) begin
                errors++;
                $display("FAIL %s cyc %0d q got %0d want %0d; {busy,wrap,done,aborted,ready} got %b want %b",
                         name, c, q, e.q, got_v[5:1], exp_v[5:1]);
            end
            if (e.chk_reps) begin
                checks++;
                if (reps_left !== e.reps) begin
                    errors++;
                    $display("FAIL %s cyc %0d reps_left got %0d want %0d",
                             name, c, reps_left, e.reps);
                end
            end
            if (c < n) begin
                abort = (c == a);
                step();
            end
        end
        abort = 1'b0;
    endtask

    // Checks that every output sits at its idle/reset value.
    task automatic expect_quiet(input string name, input logic want_ready);
        checks++;
        if (q !== 4'd0 || busy !== 1'b0 || wrap !== 1'b0 || done !== 1'b0 ||
            aborted !== 1'b0 || cmd_ready !== want_ready) begin
            errors++;
            $display("FAIL %s got q=%0d busy=%b wrap=%b done=%b aborted=%b ready=%b want q=0 busy=0 pulses=0 ready=%b",
                     name, q, busy, wrap, done, aborted, cmd_ready, want_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b1; cmd_limit = 4'd9; cmd_reps = 4'd2;
        cmd_mode = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_quiet("reset_hold", 1'b0);
            checks++;
            if (reps_left !== 4'd0) begin
                errors++;
                $display("FAIL reset_reps got %0d want 0", reps_left);
            end
        end
        rst = 1'b1; cmd_valid = 1'b0;
        step();
        expect_quiet("reset_release_no_accept", 1'b1);
    endtask

    task automatic test_counted();
        run_seq("counted_l3_r2", 3, 2, 1'b0, 0, 12, 1'b0, 0, 0);
    endtask

    task automatic test_limit_zero();
        run_seq("limit0_reps0", 0, 0, 1'b0, 0, 5, 1'b0, 0, 0);
    endtask

    task automatic test_full_sweep();
        // Continuous full-range sweep, then abort to end it.
        run_seq("cont_l15", 15, 3, 1'b1, 40, 43, 1'b0, 0, 0);
    endtask

    task automatic test_abort_at_limit();
        // q reaches 5 at cycle 7; abort there must suppress wrap.
        run_seq("abort_at_limit", 5, 3, 1'b0, 7, 10, 1'b0, 0, 0);
    endtask

    task automatic test_abort_clear();
        run_seq("abort_in_clear", 4, 1, 1'b0, 1, 4, 1'b0, 0, 0);
    endtask

    task automatic test_abort_done();
        // limit 2, one pass: DONE is cycle 5; abort there is ignored.
        run_seq("abort_in_done", 2, 1, 1'b0, 5, 8, 1'b0, 0, 0);
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_quiet("abort_idle", 1'b1);
        end
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Second command held valid throughout the first; accepted on the
        // first idle cycle, whose CLEAR then follows immediately.
        run_seq("b2b_first", 2, 1, 1'b0, 0, 6, 1'b1, 1, 2);
        run_seq("b2b_second", 1, 2, 1'b0, 0, 8, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        run_seq("midrun_pre", 10, 1, 1'b0, 0, 9, 1'b0, 0, 0);  // ends at q=7
        rst = 1'b0;
        step();
        expect_quiet("midrun_reset", 1'b0);
        checks++;
        if (reps_left !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reps got %0d want 0", reps_left);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_quiet("midrun_no_resume", 1'b1);
        end
    endtask

    task automatic test_random();
        int  lim, reps, a, n, total;
        bit  mode;
        for (int i = 0; i < 10; i++) begin
            lim  = int'($urandom_range(0, 15));
            reps = int'($urandom_range(0, 15));
            mode = 1'($urandom_range(0, 1));
            total = mode ? 0 : ((reps == 0) ? 1 : reps) * (lim + 1);
            if (mode || $urandom_range(0, 1) == 1) begin
                a = mode ? int'($urandom_range(1, 60)) : int'($urandom_range(1, total + 3));
                n = mode ? a + 3 : total + 5;
            end else begin
                a = 0;
                n = total + 4;
            end
            run_seq($sformatf("rand%0d", i), lim, reps, mode, a, n, 1'b0, 0, 0);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_counted();
        test_limit_zero();
        test_full_sweep();
        test_abort_at_limit();
        test_abort_clear();
        test_abort_done();
        test_abort_idle();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Controller that sequences a 4-bit up-counter datapath under command control. It accepts a command (terminal value, pass count, mode) over a valid/ready handshake, clears the counter, and steps it from 0 to the terminal value. It repeats for the requested number of passes, or runs continuously until aborted, then signals completion. It replaces free-running stimulus-driven counting in the top-level bench and in designs that need a programmable, restartable count sequence.

## Interface
- WIDTH, 4, counter width (q, cmd_limit)
- REP_W, 4, pass-count width (cmd_reps, reps_left)

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command; combinational, = (state==IDLE) && rst
- cmd_limit  in  WIDTH  terminal count value
- cmd_reps  in  REP_W  number of passes; 0 treated as 1
- cmd_mode  in  1  0 = counted passes, 1 = continuous, ignoring cmd_reps
- abort  in  1  stop the active sequence
- q  out  WIDTH  counter value, registered
- busy  out  1  high in CLEAR, RUN, DONE
- wrap  out  1  one-cycle pulse; q has just wrapped from limit to 0
- done  out  1  one-cycle pulse; final pass completed
- aborted  out  1  one-cycle pulse; sequence killed by abort
- reps_left  out  REP_W  passes remaining, including the current one

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE
  - cmd_ready=1.
  - cmd_valid && cmd_ready at an edge latches limit, reps (0→1) and mode, then goes to CLEAR.
  - abort is ignored.
- CLEAR: q<=0 for one cycle, then RUN.
- RUN
  - Each cycle with q!=limit: q<=q+1.
  - On q==limit: q<=0 and wrap<=1.
  - If mode==0 and reps_left==1: go to DONE with done<=1.
  - Otherwise: reps_left decrements (mode 0 only) and RUN continues.
- DONE: one cycle with q=0, then IDLE.
- Pass length is limit+1 cycles. With limit==0, q stays 0 and wrap is high every RUN cycle.
- abort in CLEAR or RUN: next edge sets q<=0, state IDLE, aborted<=1.
  - done and wrap are not asserted, even if q==limit in the same cycle; abort wins.
- abort in DONE is ignored; done still pulses.
- Commands are not accepted while busy. cmd_valid must be held until accepted.
- Arithmetic is unsigned and modulo 2^WIDTH. limit = 2^WIDTH-1 gives a full 0..15 sweep with no overflow special case.
- Reset (rst low at an edge), from any state:
  - state=IDLE, q=0, busy=0, wrap=0, done=0, aborted=0, reps_left=0, latched registers=0.
  - cmd_ready=0 while rst is low.

## Timing
- Command accepted at edge N:
  - N+1: CLEAR, busy=1.
  - N+2: RUN, q=0.
  - N+2+k: q=k.
- First wrap is visible at N+3+limit.
- In mode 0 with R passes, done is high at cycle N+2+R·(limit+1), coincident with the final wrap. cmd_ready is high one cycle later.
- abort sampled high at edge M: q=0, aborted=1 and cmd_ready=1 at M+1. A new command is accepted at M+1 at the earliest.
- wrap, done and aborted are registered, single-cycle pulses.
- There is no combinational path from inputs to q or busy.

## Structure
- Shared package count_seq_pkg:
  - state encodings (IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3)
  - default WIDTH and REP_W
  - MODE_COUNTED and MODE_CONT constants
- Sub-module seq_counter (WIDTH, clk, rst, clr, en, q):
  - synchronous clear/enable counter, instantiated once
  - the controller drives clr in CLEAR/abort and en in RUN
- Controller FSM, latched command registers and pulse generation live in count_sequencer.

## Test plan
- Reset: hold rst=0 for 3 cycles with cmd_valid=1 → q=0, busy=0, cmd_ready=0, and no command accepted.
- Counted mode, limit=3, reps=2 → q sequence 0,1,2,3,0,1,2,3,0.
  - wrap pulses twice.
  - done is coincident with the second wrap, 8 cycles after the first q=0.
  - cmd_ready returns the next cycle.
- Edge values:
  - limit=0, reps=0 → one RUN cycle with q=0, then wrap=1 and done=1 together.
  - limit=15, mode=1 → q cycles 0..15 continuously with wrap every 16 cycles, and no done.
- Abort collisions:
  - Abort at the cycle q==limit (limit=5, reps=3) → aborted=1, wrap=0, done=0, q=0, IDLE next cycle.
  - Abort in IDLE → no effect.
- Back-to-back: second command held valid during busy → not accepted until cmd_ready. Accepted on the first IDLE cycle; its CLEAR follows immediately.
- Reset mid-RUN (q=7): rst low for one edge → all outputs at reset values next cycle, and the sequence does not resume.
